// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous RAM with 1-cycle read latency.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (port 0 wins ties).
module ram_arbiter #(
  parameter int A = 10,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         we0,
  input  logic [A-1:0] addr0,
  input  logic [D-1:0] wdata0,
  output logic         gnt0,
  output logic         rvalid0,
  input  logic         req1,
  input  logic         we1,
  input  logic [A-1:0] addr1,
  input  logic [D-1:0] wdata1,
  output logic         gnt1,
  output logic         rvalid1,
  output logic [D-1:0] rdata,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_din,
  output logic         ram_we,
  input  logic [D-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           gnt0_q, gnt0_d;
  logic           gnt1_q, gnt1_d;
  logic           rvalid0_q, rvalid0_d;
  logic           rvalid1_q, rvalid1_d;
  logic [D-1:0]   rdata_q, rdata_d;
  logic [A-1:0]   ramAddr_q, ramAddr_d;
  logic [D-1:0]   ramDin_q, ramDin_d;
  logic           ramWe_q, ramWe_d;
  logic           winner_q, winner_d;
  logic           readPending_q, readPending_d;
  logic           anyReq;
  logic           pick1;

  assign anyReq = req0 | req1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // lastWinner_q = 1 means port 1 took the previous grant, so port 0 wins the next tie
  logic lastWinner_q, lastWinner_d;
  assign pick1 = req1 & (~req0 | ~lastWinner_q);
`else
  assign pick1 = ~req0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      rdata_q       <= '0;
      ramAddr_q     <= '0;
      ramDin_q      <= '0;
      ramWe_q       <= 1'b0;
      winner_q      <= 1'b0;
      readPending_q <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      lastWinner_q  <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      rdata_q       <= rdata_d;
      ramAddr_q     <= ramAddr_d;
      ramDin_q      <= ramDin_d;
      ramWe_q       <= ramWe_d;
      winner_q      <= winner_d;
      readPending_q <= readPending_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      lastWinner_q  <= lastWinner_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyReq) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes default low so gnt, ram_we and rvalid are single-cycle pulses
  always_comb begin
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    rvalid0_d     = 1'b0;
    rvalid1_d     = 1'b0;
    ramWe_d       = 1'b0;
    rdata_d       = rdata_q;
    ramAddr_d     = ramAddr_q;
    ramDin_d      = ramDin_q;
    winner_d      = winner_q;
    readPending_d = readPending_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    lastWinner_d  = lastWinner_q;
`endif
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          winner_d  = pick1;
          ramAddr_d = pick1 ? addr1 : addr0;
          ramDin_d  = pick1 ? wdata1 : wdata0;
          ramWe_d   = pick1 ? we1 : we0;
          gnt0_d    = ~pick1;
          gnt1_d    = pick1;
`ifdef RAM_ARB_ROUND_ROBIN_EN
          lastWinner_d = pick1;
`endif
        end
      end
      ISSUE: begin
        readPending_d = ~ramWe_q;
      end
      RESP: begin
        if (readPending_q) begin
          rdata_d   = ram_dout;
          rvalid0_d = ~winner_q;
          rvalid1_d = winner_q;
        end
        readPending_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata    = rdata_q;
  assign ram_addr = ramAddr_q;
  assign ram_din  = ramDin_q;
  assign ram_we   = ramWe_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of one ram_sync instance (single port, 1-cycle registered read).
- Typical pairing: port 0 = CPU datapath, port 1 = UART/program loader.
- Serialises accesses, drives the RAM's addr/din/we, and returns read data with a valid strobe to the winning port.

Parameters:
A, 10, RAM address width; must match the attached ram_sync A.
D, 8, RAM data width; must match the attached ram_sync D.

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous reset, active-high
req0  input  1  port 0 request; held with we0/addr0/wdata0 stable until gnt0
we0  input  1  port 0 write (1) / read (0)
addr0  input  A  port 0 address
wdata0  input  D  port 0 write data
gnt0  output  1  one-cycle pulse: port 0 access issued to RAM
rvalid0  output  1  one-cycle pulse: port 0 read data on rdata
req1  input  1  port 1 request; same rules as port 0
we1  input  1  port 1 write/read
addr1  input  A  port 1 address
wdata1  input  D  port 1 write data
gnt1  output  1  one-cycle pulse: port 1 access issued
rvalid1  output  1  one-cycle pulse: port 1 read data on rdata
rdata  output  D  read data, shared by both ports; qualified by rvalid0/rvalid1
ram_addr  output  A  to ram_sync addr
ram_din  output  D  to ram_sync din
ram_we  output  1  to ram_sync we
ram_dout  input  D  from ram_sync dout

Behaviour:
- Reset (async, immediate): state=IDLE; gnt0, gnt1, rvalid0, rvalid1, ram_we = 0; ram_addr, ram_din, rdata = 0; last-winner = port 1 (so port 0 wins first).
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Any req: pick winner, load ram_addr/ram_din/ram_we from the winner (ram_we = winner's we), set gnt_winner, go to ISSUE.
- ISSUE (1 cycle):
  - gnt_winner = 1; the RAM samples addr/we at the closing edge.
  - On exit: ram_we is cleared and gnt_winner is cleared.
  - If the access is a read, set a pending-read flag.
  - Go to RESP.
- RESP (1 cycle):
  - ram_dout is valid.
  - Read: rdata <= ram_dout and rvalid_winner is set for the following cycle (IDLE).
  - Write: no rvalid.
  - Go to IDLE.
- Timing: request sampled at edge E. gnt is high during cycle E+1. Read data and rvalid are high during cycle E+3. Throughput is one access per 3 cycles.
- rdata holds its last value when rvalid is low.
- Requester protocol: deassert req (or present a new request) in the cycle after gnt is seen. A req still high in IDLE is treated as a new access.
- Arbitration is fixed priority, port 0 over port 1 (see Optional Feature).
- Changing addr/we/wdata while req is high and before gnt: undefined for that port; the bench must not do this.
- Both req high in IDLE: exactly one gnt; the loser stays pending and is served in the next IDLE with no extra delay.
- Reset mid-operation:
  - ram_we drops immediately; an in-flight write in ISSUE is not performed if rst rises before the closing edge.
  - An in-flight read produces no rvalid.
- gnt0 and gnt1 are never high together; rvalid0 and rvalid1 are never high together.

Optional Feature:
- Macro: RAM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin. When both ports request, the port that did not win the last grant wins. last-winner updates on every grant. A lone requester always wins. Neither port waits more than one foreign access.
- Undefined: fixed priority, port 0 always wins a tie. last-winner is not implemented. Port 1 can starve under continuous port 0 traffic.

Test Plan:
- Port 0 write addr 0x005 data 0xA5, then port 0 read 0x005 -> gnt0 one cycle after req sample; ram_we high exactly one cycle; rvalid0 with rdata=0xA5 three cycles after read req sample.
- Port 1 writes 0x3FF=0x3C, then reads 0x3FF -> rdata=0x3C with rvalid1; gnt0 and rvalid0 stay 0 throughout.
- req0 and req1 both rise together, both reads (0x001=0x11, 0x002=0x22 preloaded) -> port 0 served first (rvalid0, 0x11), then port 1 (rvalid1, 0x22) exactly 3 cycles later.
- With RAM_ARB_ROUND_ROBIN_EN: both ports request continuously for 6 accesses -> grants alternate 0,1,0,1,0,1. Without the macro -> port 0 receives all 6 grants.
- Assert rst while in ISSUE of a port 0 write of 0x77 to 0x010 (prior content 0x00) -> ram_we, gnt0 and all outputs drop to 0 immediately, state returns to IDLE, and a later read of 0x010 returns 0x00.
- Release rst with req1 already high -> first grant is gnt1 one cycle after the first post-reset edge; no spurious rvalid before it.
